// File: rtl/minmax_tracker_pkg.sv
// Shared types and default widths for the min/max frame tracker.
package minmax_tracker_pkg;

  localparam int unsigned DATAWIDTH_DEF  = 8;
  localparam int unsigned COUNTWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/minmax_tracker_comp.sv
// Unsigned magnitude comparator: flags a<b, a>b and a==b.
module COMP #(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 lt,
  output logic                 gt,
  output logic                 eq
);

  // Pure combinational compare, full width, no sign handling.
  always_comb begin
    lt = (a < b);
    gt = (a > b);
    eq = (a == b);
  end

endmodule

// File: rtl/minmax_tracker.sv
// Tracks running min/max (and first-occurrence index) over a frame of
// unsigned samples received on a valid/ready stream; pulses done at frame end.
module minmax_tracker
  import minmax_tracker_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = DATAWIDTH_DEF,
  parameter int unsigned COUNTWIDTH = COUNTWIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [COUNTWIDTH-1:0] frame_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATAWIDTH-1:0]  in_data,
  output logic [DATAWIDTH-1:0]  min_out,
  output logic [DATAWIDTH-1:0]  max_out,
  output logic [COUNTWIDTH-1:0] min_idx,
  output logic [COUNTWIDTH-1:0] max_idx,
  output logic [COUNTWIDTH-1:0] count,
  output logic                  busy,
  output logic                  done
);

  state_t                  state;
  state_t                  state_next;
  logic [COUNTWIDTH-1:0]   frame_len_reg;
  logic                    start_ok;
  logic                    accept;
  logic                    last_accept;
  logic                    min_lt;
  logic                    max_gt;
  logic                    unused_min_eq;
  logic                    unused_max_eq;

  COMP #(.DATAWIDTH(DATAWIDTH)) u_comp_min (
    .a  (in_data),
    .b  (min_out),
    .lt (min_lt),
    .gt (),
    .eq (unused_min_eq)
  );

  COMP #(.DATAWIDTH(DATAWIDTH)) u_comp_max (
    .a  (in_data),
    .b  (max_out),
    .lt (),
    .gt (max_gt),
    .eq (unused_max_eq)
  );

  // Handshake qualifiers shared by the FSM and the datapath.
  always_comb begin
    start_ok    = (state == ST_IDLE) && start && (frame_len != '0);
    accept      = (state == ST_RUN) && in_valid;
    last_accept = accept && (count == (frame_len_reg - COUNTWIDTH'(1)));
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_next = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_accept) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame length capture, sample counter and result registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      frame_len_reg <= '0;
      count         <= '0;
      min_out       <= '0;
      max_out       <= '0;
      min_idx       <= '0;
      max_idx       <= '0;
    end else if (start_ok) begin
      frame_len_reg <= frame_len;
      count         <= '0;
    end else if (accept) begin
      count <= count + COUNTWIDTH'(1);
      // First sample seeds both extremes; the comparators see stale results then.
      if (count == '0) begin
        min_out <= in_data;
        max_out <= in_data;
        min_idx <= '0;
        max_idx <= '0;
      end else begin
        if (min_lt) begin
          min_out <= in_data;
          min_idx <= count;
        end
        if (max_gt) begin
          max_out <= in_data;
          max_idx <= count;
        end
      end
    end
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed testbench for minmax_tracker with hand-computed expectations.
module tb_minmax_tracker;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       start;
  logic [7:0] frame_len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] min_out;
  logic [7:0] max_out;
  logic [7:0] min_idx;
  logic [7:0] max_idx;
  logic [7:0] count;
  logic       busy;
  logic       done;

  int unsigned total = 0;
  int unsigned fails = 0;

  minmax_tracker #(.DATAWIDTH(8), .COUNTWIDTH(8)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .min_out   (min_out),
    .max_out   (max_out),
    .min_idx   (min_idx),
    .max_idx   (max_idx),
    .count     (count),
    .busy      (busy),
    .done      (done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] mn, input logic [7:0] mni,
                         input logic [7:0] mx, input logic [7:0] mxi);
    chk({tag, ".min_out"}, 32'(min_out), 32'(mn));
    chk({tag, ".min_idx"}, 32'(min_idx), 32'(mni));
    chk({tag, ".max_out"}, 32'(max_out), 32'(mx));
    chk({tag, ".max_idx"}, 32'(max_idx), 32'(mxi));
  endtask

  task automatic begin_frame(input logic [7:0] len);
    start     = 1'b1;
    frame_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    Rst = 1'b0;

    // Reset state
    chk_res("rst", 0, 0, 0, 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.in_ready", 32'(in_ready), 0);

    // Basic frame: 5,3,9,3
    begin_frame(8'd4);
    chk("basic.busy", 32'(busy), 1);
    chk("basic.in_ready", 32'(in_ready), 1);
    chk("basic.count0", 32'(count), 0);
    send(8'd5);
    chk_res("basic.s0", 5, 0, 5, 0);
    send(8'd3);
    send(8'd9);
    chk("basic.done_early", 32'(done), 0);
    chk("basic.count3", 32'(count), 3);
    send(8'd3);
    chk("basic.done", 32'(done), 1);
    chk("basic.ready_done", 32'(in_ready), 0);
    chk("basic.count4", 32'(count), 4);
    chk_res("basic", 3, 1, 9, 2);
    tick();
    chk("basic.done_pulse", 32'(done), 0);
    chk("basic.idle_busy", 32'(busy), 0);

    // Valid gaps: 200, gap3, 10, gap1, 255
    begin_frame(8'd3);
    send(8'd200);
    tick(); tick(); tick();
    chk_res("gap.hold1", 200, 0, 200, 0);
    chk("gap.count1", 32'(count), 1);
    send(8'd10);
    tick();
    chk_res("gap.hold2", 10, 1, 200, 0);
    chk("gap.count2", 32'(count), 2);
    send(8'd255);
    chk("gap.done", 32'(done), 1);
    chk_res("gap", 10, 1, 255, 2);
    tick();

    // frame_len=0 start is ignored
    begin_frame(8'd0);
    chk("zero.busy", 32'(busy), 0);
    chk("zero.done", 32'(done), 0);
    tick();
    chk("zero.busy2", 32'(busy), 0);
    chk_res("zero.keep", 10, 1, 255, 2);

    // Single-sample frame
    begin_frame(8'd1);
    send(8'd7);
    chk("one.done", 32'(done), 1);
    chk("one.count", 32'(count), 1);
    chk_res("one", 7, 0, 7, 0);
    tick();

    // Equal samples; start during DONE is ignored
    begin_frame(8'd5);
    for (int i = 0; i < 5; i++) send(8'd42);
    chk("eq.done", 32'(done), 1);
    chk_res("eq", 42, 0, 42, 0);
    start = 1'b1; frame_len = 8'd3;
    tick();
    start = 1'b0;
    chk("eq.start_in_done", 32'(busy), 0);
    tick();
    chk("eq.still_idle", 32'(busy), 0);

    // Reset mid-frame
    begin_frame(8'd4);
    send(8'd50);
    send(8'd60);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk_res("midrst", 0, 0, 0, 0);
    chk("midrst.count", 32'(count), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.in_ready", 32'(in_ready), 0);
    chk("midrst.done", 32'(done), 0);
    begin_frame(8'd2);
    send(8'd1);
    send(8'd2);
    chk("post.done", 32'(done), 1);
    chk_res("post", 1, 0, 2, 1);
    tick();

    // Start during RUN is ignored
    begin_frame(8'd2);
    start = 1'b1; frame_len = 8'd9;
    send(8'd11);
    start = 1'b0;
    send(8'd4);
    chk("ign.done", 32'(done), 1);
    chk("ign.count", 32'(count), 2);
    chk_res("ign", 4, 1, 11, 0);
    tick();
    chk("ign.idle", 32'(busy), 0);
    chk("ign.done_pulse", 32'(done), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
